// File: rtl/div_pkg.sv
// Shared types for the RV32M iterative divider: datapath word and divide-op encoding.
package div_pkg;

  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'd0,
    DIV_DIVU = 2'd1,
    DIV_REM  = 2'd2,
    DIV_REMU = 2'd3
  } div_op_t;

  localparam word INT_MIN = 32'h8000_0000;

  // Magnitude of a signed operand; INT_MIN maps onto itself, which is correct as unsigned.
  function automatic word abs_word(input word x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit, trial-subtract, emit a quotient bit.
module div_step
  import div_pkg::*;
(
  input  logic [32:0] rem,
  input  word         dividend,
  input  word         divisor,
  output logic [32:0] rem_next,
  output word         dividend_next
);

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        q_bit;
  // The stored remainder is always below the divisor, so its top bit never carries information.
  logic        unused_rem_msb;

  assign unused_rem_msb = rem[32];

  always_comb begin
    shifted       = {rem[31:0], dividend[31]};
    diff          = shifted - {1'b0, divisor};
    q_bit         = (shifted >= {1'b0, divisor});
    rem_next      = q_bit ? diff : shifted;
    dividend_next = {dividend[30:0], q_bit};
  end

endmodule

// File: rtl/div.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle, valid/ready on both sides.
module div
  import div_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    in_valid,
  output logic    in_ready,
  input  word     a,
  input  word     b,
  input  div_op_t op,
  input  logic    kill,
  output logic    out_valid,
  input  logic    out_ready,
  output word     res
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  div_op_t     op_q;
  logic        neg_q, neg_r;
  word         dvd, dvs, res_q;
  logic [32:0] rem;
  logic [4:0]  cnt;

  logic        accept;
  logic        signed_in, is_div_in, div_zero, overflow, special;
  word         special_res;
  logic [32:0] step_rem;
  word         step_dvd;
  word         q_mag, r_mag, calc_res;
  logic        rem_op;

  div_step u_step (
    .rem           (rem),
    .dividend      (dvd),
    .divisor       (dvs),
    .rem_next      (step_rem),
    .dividend_next (step_dvd)
  );

  always_comb begin
    signed_in   = (op == DIV_DIV) || (op == DIV_REM);
    is_div_in   = (op == DIV_DIV) || (op == DIV_DIVU);
    div_zero    = (b == '0);
    overflow    = signed_in && (a == INT_MIN) && (b == '1);
    special     = div_zero || overflow;
    special_res = div_zero ? (is_div_in ? '1 : a) : (is_div_in ? INT_MIN : '0);

    q_mag    = step_dvd;
    r_mag    = step_rem[31:0];
    rem_op   = (op_q == DIV_REM) || (op_q == DIV_REMU);
    calc_res = rem_op ? (neg_r ? (~r_mag + 32'd1) : r_mag)
                      : (neg_q ? (~q_mag + 32'd1) : q_mag);
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        accept     = 1'b1;
        state_next = special ? DONE : CALC;
      end
      CALC: if (cnt == 5'd0) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill) begin
      state_next = IDLE;
      accept     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q  <= DIV_DIV;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else if (accept) begin
      op_q  <= op;
      neg_q <= signed_in && (a[31] ^ b[31]);
      neg_r <= signed_in && a[31];
      dvd   <= abs_word(a, signed_in);
      dvs   <= abs_word(b, signed_in);
      rem   <= '0;
      cnt   <= 5'd31;
      if (special) res_q <= special_res;
    end else if (state == CALC && !kill) begin
      rem <= step_rem;
      dvd <= step_dvd;
      cnt <= cnt - 5'd1;
      if (cnt == 5'd0) res_q <= calc_res;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign res       = res_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed RV32M cases, backpressure, abort paths and randomized ops.
module tb_div;
  import div_pkg::*;

  logic    clk = 1'b0;
  logic    reset = 1'b0;
  logic    in_valid = 1'b0;
  logic    in_ready;
  word     a = '0;
  word     b = '0;
  div_op_t op = DIV_DIV;
  logic    kill = 1'b0;
  logic    out_valid;
  logic    out_ready = 1'b0;
  word     res;

  int checks = 0;
  int failures = 0;

  div dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
  );

  always #5 clk = ~clk;

  // RV32M reference semantics from plain arithmetic.
  function automatic word model(input word x, input word y, input div_op_t o);
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    if (y == '0) return ((o == DIV_DIV) || (o == DIV_DIVU)) ? 32'hFFFF_FFFF : x;
    case (o)
      DIV_DIV:  return (x == INT_MIN && y == 32'hFFFF_FFFF) ? INT_MIN : word'(sx / sy);
      DIV_REM:  return (x == INT_MIN && y == 32'hFFFF_FFFF) ? 32'd0 : word'(sx % sy);
      DIV_DIVU: return x / y;
      default:  return x % y;
    endcase
  endfunction

  function automatic int model_lat(input word x, input word y, input div_op_t o);
    logic sgn;
    sgn = (o == DIV_DIV) || (o == DIV_REM);
    return (y == '0 || (sgn && x == INT_MIN && y == 32'hFFFF_FFFF)) ? 1 : 33;
  endfunction

  // Issues one op from IDLE and waits (bounded) for out_valid; latency counts the accept edge as 1.
  task automatic run_op(input word ta, input word tb_in, input div_op_t to,
                        output word got, output int lat);
    a = ta;
    b = tb_in;
    op = to;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got = res;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 32'd0) begin
      failures++;
      $display("FAIL reset_state in_ready=%b out_valid=%b res=%h required 1 0 00000000",
               in_ready, out_valid, res);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    word     ta[12]  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                         32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678,
                         32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    word     tbv[12] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE,
                         32'd0, 32'd0, 32'd0, 32'd0,
                         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    div_op_t to[12]  = '{DIV_DIVU, DIV_REMU, DIV_DIV, DIV_REM, DIV_REM,
                         DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU,
                         DIV_DIV, DIV_REM, DIV_DIVU};
    word     te[12]  = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
                         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678,
                         32'h8000_0000, 32'd0, 32'd0};
    int      tl[12]  = '{33, 33, 33, 33, 33, 1, 1, 1, 1, 1, 1, 33};
    word got;
    int  lat;
    for (int i = 0; i < 12; i++) begin
      run_op(ta[i], tbv[i], to[i], got, lat);
      checks++;
      if (got !== te[i] || lat != tl[i]) begin
        failures++;
        $display("FAIL directed_%0d res=%h lat=%0d required res=%h lat=%0d",
                 i, got, lat, te[i], tl[i]);
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    word got;
    int  lat;
    run_op(32'd100, 32'd7, DIV_DIVU, got, lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || res !== 32'd14 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold_%0d out_valid=%b res=%h in_ready=%b required 1 0000000e 0",
                 i, out_valid, res, in_ready);
      end
      @(posedge clk); #1;
    end
    drain();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic abort_mid_calc(input logic use_reset, input string tag);
    word got;
    int  lat;
    int  seen;
    a = 32'hFFFF_FFFF;
    b = 32'd3;
    op = DIV_DIVU;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    if (use_reset) begin
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 32'd0) begin
        failures++;
        $display("FAIL %s_async in_ready=%b out_valid=%b res=%h required 1 0 00000000",
                 tag, in_ready, out_valid, res);
      end
      @(posedge clk); #1;
      reset = 1'b1;
    end else begin
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle in_ready=%b out_valid=%b required 1 0", tag, in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL %s_no_result out_valid_cycles=%0d required 0", tag, seen);
    end
    run_op(32'hFFFF_FFFF, 32'd3, DIV_DIVU, got, lat);
    checks++;
    if (got !== 32'h5555_5555 || lat != 33) begin
      failures++;
      $display("FAIL %s_reissue res=%h lat=%0d required res=55555555 lat=33", tag, got, lat);
    end
    drain();
  endtask

  task automatic test_kill();
    abort_mid_calc(1'b0, "kill");
    a = 32'd9;
    b = 32'd3;
    op = DIV_DIVU;
    in_valid = 1'b1;
    kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    kill = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL kill_blocks_accept in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_abort();
    abort_mid_calc(1'b1, "reset_abort");
  endtask

  task automatic test_random();
    word     ta, tbv, got, exp;
    div_op_t to;
    int      lat, exp_lat;
    for (int i = 0; i < 40; i++) begin
      ta  = $urandom;
      tbv = $urandom;
      case ($urandom_range(0, 7))
        0: tbv = '0;
        1: begin ta = INT_MIN; tbv = 32'hFFFF_FFFF; end
        2: begin ta = $urandom_range(0, 1000); tbv = $urandom_range(1, 40); end
        3: tbv = $urandom_range(1, 15) | (tbv & 32'h8000_0000);
        default: ;
      endcase
      to      = div_op_t'($urandom_range(0, 3));
      exp     = model(ta, tbv, to);
      exp_lat = model_lat(ta, tbv, to);
      run_op(ta, tbv, to, got, lat);
      checks++;
      if (got !== exp || lat != exp_lat) begin
        failures++;
        $display("FAIL random_%0d op=%s a=%h b=%h res=%h lat=%0d required res=%h lat=%0d",
                 i, to.name(), ta, tbv, got, lat, exp, exp_lat);
      end
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_kill();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
